// File: rtl/uart_alu_interface.sv
// Byte sequencer between uart_rx and uart_tx: gathers A, B and opcode for an
// external combinational ALU, then hands the captured result to the transmitter.
module uart_alu_interface #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_data_a,
  output logic [NB_DATA-1:0] o_data_b,
  output logic [NB_OP-1:0]   o_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_overrun,
  output logic [2:0]         o_dbg_state
);

  // Handshake: i_rx_done and i_tx_done are single-cycle pulses with no ready
  // back-pressure; a byte pulsed while busy is lost and flagged by o_overrun.
  // o_tx_start is a single-cycle strobe qualifying o_tx_data.
  typedef enum logic [2:0] {
    S_A   = 3'd0,
    S_B   = 3'd1,
    S_OP  = 3'd2,
    S_RES = 3'd3,
    S_TX  = 3'd4
  } state_t;

  state_t             state_q;
  logic [NB_DATA-1:0] data_a_q;
  logic [NB_DATA-1:0] data_b_q;
  logic [NB_OP-1:0]   op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               busy_q;
  logic               overrun_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_A;
      data_a_q   <= '0;
      data_b_q   <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      overrun_q  <= 1'b0;
      case (state_q)
        S_A: begin
          if (i_rx_done) begin
            data_a_q <= i_rx_data;
            state_q  <= S_B;
          end
        end
        S_B: begin
          if (i_rx_done) begin
            data_b_q <= i_rx_data;
            state_q  <= S_OP;
          end
        end
        S_OP: begin
          if (i_rx_done) begin
            op_q    <= i_rx_data[NB_OP-1:0];
            busy_q  <= 1'b1;
            state_q <= S_RES;
          end
        end
        S_RES: begin
          // ALU inputs settled during the previous cycle; capture now.
          tx_data_q  <= i_alu_result;
          tx_start_q <= 1'b1;
          state_q    <= S_TX;
          if (i_rx_done) overrun_q <= 1'b1;
        end
        S_TX: begin
          if (i_rx_done) overrun_q <= 1'b1;
          if (i_tx_done) begin
            busy_q  <= 1'b0;
            state_q <= S_A;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_A;
        end
      endcase
    end
  end

  assign o_data_a    = data_a_q;
  assign o_data_b    = data_b_q;
  assign o_op        = op_q;
  assign o_tx_data   = tx_data_q;
  assign o_tx_start  = tx_start_q;
  assign o_busy      = busy_q;
  assign o_overrun   = overrun_q;
  assign o_dbg_state = state_q;

endmodule

// File: doc/uart_alu_interface.md
# uart_alu_interface

Byte-level sequencer sitting directly downstream of `uart_rx` and upstream of the `uart_tx` stage. It collects three consecutive received bytes (operand A, operand B, opcode), presents them as registered inputs to an external combinational ALU, and captures the ALU result one cycle later. It then hands the result to the transmitter with a single-cycle start strobe and waits for the transmitter's done pulse before accepting a new frame.

## Interface

Parameters:

- `NB_DATA`, 8 — width of received bytes, operands, ALU result and TX byte.
- `NB_OP`, 6 — opcode width; taken from the low `NB_OP` bits of the third byte.

Ports:

- `clk`  in  1  — single system clock; all state updates on its rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `i_rx_done`  in  1  — one-cycle pulse from `uart_rx`: `i_rx_data` is valid.
- `i_rx_data`  in  `NB_DATA`  — received byte from `uart_rx`.
- `i_alu_result`  in  `NB_DATA`  — combinational ALU output driven from `o_data_a`, `o_data_b` and `o_op`.
- `i_tx_done`  in  1  — one-cycle pulse from `uart_tx`: byte fully sent.
- `o_data_a`  out  `NB_DATA`  — registered operand A.
- `o_data_b`  out  `NB_DATA`  — registered operand B.
- `o_op`  out  `NB_OP`  — registered opcode.
- `o_tx_data`  out  `NB_DATA`  — registered result byte for `uart_tx`.
- `o_tx_start`  out  1  — one-cycle strobe; starts transmission of `o_tx_data`.
- `o_busy`  out  1  — high while in `S_RES` or `S_TX`.
- `o_overrun`  out  1  — one-cycle pulse: a byte arrived while busy and was dropped.

## Operation

- FSM states, with reset state `S_A`:
  - `S_A`: wait for operand A.
  - `S_B`: wait for operand B.
  - `S_OP`: wait for the opcode.
  - `S_RES`: capture the ALU result.
  - `S_TX`: wait for transmission to complete.
- Transitions:
  - `S_A`: on `i_rx_done`, `o_data_a <= i_rx_data`, go to `S_B`.
  - `S_B`: on `i_rx_done`, `o_data_b <= i_rx_data`, go to `S_OP`.
  - `S_OP`: on `i_rx_done`, `o_op <= i_rx_data[NB_OP-1:0]`, go to `S_RES`. Upper bits are discarded.
  - `S_RES`: unconditional, one cycle. `o_tx_data <= i_alu_result`, `o_tx_start <= 1`, go to `S_TX`.
  - `S_TX`: on `i_tx_done`, go to `S_A`. Otherwise stay.
- `o_tx_start` is registered and defaults to 0 every cycle except the `S_RES`→`S_TX` edge.
- Operand and opcode registers hold their value until overwritten by a new frame. They are never cleared except by reset.
- `i_rx_done` in `S_RES` or `S_TX`: the byte is dropped, `o_overrun` pulses high for 1 cycle, and state and registers are unchanged.
- `i_tx_done` outside `S_TX` is ignored.
- Simultaneous `i_tx_done` and `i_rx_done` in `S_TX`: the FSM moves to `S_A`, the byte is dropped, and `o_overrun` pulses.
- Reset asserted at any point forces the FSM to `S_A` immediately, discards any partial frame, and aborts any pending TX handshake.
- No internal arithmetic; all widths pass through unchanged.

## Timing

- Reset values: `o_data_a`, `o_data_b`, `o_op`, `o_tx_data`, `o_tx_start`, `o_busy`, `o_overrun` are all 0; state is `S_A`.
- A byte whose `i_rx_done` is sampled high at edge k appears on its output register after edge k.
- Opcode sampled at edge k:
  - ALU inputs are stable after k.
  - `o_tx_data` and `o_tx_start` are valid after edge k+1.
  - `o_tx_start` falls after edge k+2.
- `o_busy` rises after edge k and falls after the edge that samples `i_tx_done`.
- The next byte is accepted no earlier than the cycle after return to `S_A`.
- The ALU must settle within 1 clock; it is combinational, with no handshake.

## Test plan

- **Basic frame.** Reset, then rx bytes 0x05, 0x03, 0x20 with an ALU model of ADD for 0x20. Required: `o_data_a`=0x05, `o_data_b`=0x03, `o_op`=0x20, `o_tx_data`=0x08, `o_tx_start` high exactly 1 cycle, 1 cycle after the opcode is latched.
- **Opcode masking.** Send third byte 0xE2. Required: `o_op`=0x22.
- **Back-to-back frames.** Two frames with `i_tx_done` between them, second frame 0xFF, 0x01, SUB. Required: second `o_tx_data`=0xFE, and operands from frame 1 are held until overwritten.
- **Overrun.** Send byte 0x7A while in `S_TX`, before `i_tx_done`. Required: `o_overrun` pulses 1 cycle, `o_data_a` is unchanged, and the next frame is processed correctly after `i_tx_done`.
- **Reset mid-frame.** Assert reset after operand B = 0x11, release it, then send a full frame 0x02, 0x02, ADD. Required: all outputs 0 during reset, and `o_tx_data`=0x04.
- **Stray `i_tx_done`.** Pulse `i_tx_done` in `S_A`/`S_B`, then pulse `i_rx_done` and `i_tx_done` simultaneously in `S_TX`. Required: the stray pulse is ignored; the simultaneous case returns to `S_A` and pulses `o_overrun`.
